// File: rtl/bcd_counter_pkg.sv
// rtl/bcd_counter_pkg.sv - shared constants and types for the cascaded modulo-RADIX counter
package bcd_counter_pkg;

  localparam int MAX_DIGITS = 8;
  localparam int MAX_RADIX  = 16;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/counter_digit.sv
// rtl/counter_digit.sv - one modulo-RADIX digit with load, up/down step and end-of-range flags
module counter_digit
  import bcd_counter_pkg::*;
#(
  parameter int RADIX = 10,
  parameter int DW    = 4
) (
  input  logic          CLK,
  input  logic          MR_n,
  input  logic          load,
  input  logic [DW-1:0] d,
  input  logic          en,
  input  logic          up,
  output logic [DW-1:0] q,
  output logic          at_max,
  output logic          at_min
);

  localparam logic [DW:0]   RADIX_W = (DW+1)'(RADIX);
  localparam logic [DW-1:0] MAX_V   = DW'(RADIX - 1);

  logic [DW-1:0] r_q;
  logic [DW-1:0] w_load_val;
  dir_e          w_dir;

  assign w_dir = dir_e'(up);
  // Out-of-range load values collapse to 0 so a digit never leaves 0..RADIX-1.
  assign w_load_val = ({1'b0, d} >= RADIX_W) ? '0 : d;

  always_ff @(posedge CLK) begin
    if (!MR_n) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= w_load_val;
    end else if (en) begin
      if (w_dir == DIR_UP) begin
        r_q <= at_max ? '0 : r_q + 1'b1;
      end else begin
        r_q <= at_min ? MAX_V : r_q - 1'b1;
      end
    end
  end

  assign q      = r_q;
  assign at_max = (r_q == MAX_V);
  assign at_min = (r_q == '0);

endmodule

// File: rtl/bcd_cascade_counter.sv
// rtl/bcd_cascade_counter.sv - multi-digit modulo-RADIX up/down counter with load, carry chain and wrap flags
module bcd_cascade_counter
  import bcd_counter_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int RADIX  = 10
) (
  input  logic                       CLK,
  input  logic                       MR_n,
  input  logic                       Enable,
  input  logic                       Up,
  input  logic                       Load,
  input  logic [DIGITS*$clog2(RADIX)-1:0] P,
  input  logic                       ClrOvf,
  output logic [DIGITS*$clog2(RADIX)-1:0] Q,
  output logic                       TC,
  output logic                       Wrap,
  output logic                       Ovf,
  output logic                       LoadErr
);

  localparam int          DW      = $clog2(RADIX);
  localparam logic [DW:0] RADIX_W = (DW+1)'(RADIX);

  if (DIGITS < 1 || DIGITS > MAX_DIGITS || RADIX < 2 || RADIX > MAX_RADIX) begin : g_bad_param
    $error("bcd_cascade_counter: DIGITS or RADIX out of range");
  end

  logic [DIGITS:0]   w_chain;
  logic [DIGITS-1:0] w_at_max;
  logic [DIGITS-1:0] w_at_min;
  logic [DIGITS-1:0] w_bad;
  logic              w_wrap;
  dir_e              w_dir;

  logic r_wrap;
  logic r_ovf;
  logic r_load_err;

  assign w_dir      = dir_e'(Up);
  assign w_chain[0] = 1'b1;

  // w_chain[i] is high when every digit below i sits at its end of range for the current direction.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    counter_digit #(
      .RADIX (RADIX),
      .DW    (DW)
    ) u_digit (
      .CLK    (CLK),
      .MR_n   (MR_n),
      .load   (Load),
      .d      (P[i*DW +: DW]),
      .en     (Enable & w_chain[i]),
      .up     (Up),
      .q      (Q[i*DW +: DW]),
      .at_max (w_at_max[i]),
      .at_min (w_at_min[i])
    );

    assign w_chain[i+1] = w_chain[i] & ((w_dir == DIR_UP) ? w_at_max[i] : w_at_min[i]);
    assign w_bad[i]     = ({1'b0, P[i*DW +: DW]} >= RADIX_W);
  end

  assign TC     = Enable & w_chain[DIGITS];
  assign w_wrap = TC & ~Load;

  always_ff @(posedge CLK) begin
    if (!MR_n) begin
      r_wrap     <= 1'b0;
      r_ovf      <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_wrap     <= w_wrap;
      r_load_err <= Load & (|w_bad);
      if (w_wrap) begin
        r_ovf <= 1'b1;
      end else if (ClrOvf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign Wrap    = r_wrap;
  assign Ovf     = r_ovf;
  assign LoadErr = r_load_err;

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// tb/tb_bcd_cascade_counter.sv - scoreboard bench for the cascaded counter and a two-instance chain
module tb_bcd_cascade_counter;

  logic       clk;
  logic       MR_n, Enable, Up, Load, ClrOvf;
  logic [7:0] P;
  logic [7:0] Q;
  logic       TC, Wrap, Ovf, LoadErr;

  logic       ch_mr, ch_en0, ch_load, ch_clr;
  logic [2:0] ch_p, q0, q1;
  logic       tc0, tc1, wrap0, wrap1, ovf0, ovf1, le0, le1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      tag;
    logic [7:0] q;
    logic       wrap;
    logic       ovf;
    logic       le;
  } exp_t;

  exp_t sb[$];

  int m_val   = 0;
  bit m_ovf   = 0;
  bit m_known = 0;

  bcd_cascade_counter #(.DIGITS(2), .RADIX(10)) dut (
    .CLK(clk), .MR_n(MR_n), .Enable(Enable), .Up(Up), .Load(Load), .P(P),
    .ClrOvf(ClrOvf), .Q(Q), .TC(TC), .Wrap(Wrap), .Ovf(Ovf), .LoadErr(LoadErr)
  );

  bcd_cascade_counter #(.DIGITS(1), .RADIX(6)) u_c0 (
    .CLK(clk), .MR_n(ch_mr), .Enable(ch_en0), .Up(1'b1), .Load(ch_load), .P(ch_p),
    .ClrOvf(ch_clr), .Q(q0), .TC(tc0), .Wrap(wrap0), .Ovf(ovf0), .LoadErr(le0)
  );

  bcd_cascade_counter #(.DIGITS(1), .RADIX(6)) u_c1 (
    .CLK(clk), .MR_n(ch_mr), .Enable(tc0), .Up(1'b1), .Load(ch_load), .P(ch_p),
    .ClrOvf(ch_clr), .Q(q1), .TC(tc1), .Wrap(wrap1), .Ovf(ovf1), .LoadErr(le1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    to_bcd = {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic step(input string tag, input logic mr, input logic en, input logic up,
                      input logic ld, input logic [7:0] p, input logic clr);
    exp_t e;
    int   d0, d1;
    bit   tc_exp;
    bit   wrap_exp;
    bit   le_exp;

    tc_exp   = en && (up ? (m_val == 99) : (m_val == 0));
    wrap_exp = 0;
    le_exp   = 0;
    if (!mr) begin
      m_val = 0;
      m_ovf = 0;
    end else if (ld) begin
      d0 = int'(p[3:0]);
      d1 = int'(p[7:4]);
      if (d0 > 9) begin d0 = 0; le_exp = 1; end
      if (d1 > 9) begin d1 = 0; le_exp = 1; end
      m_val = d1 * 10 + d0;
      if (clr) m_ovf = 0;
    end else begin
      if (en) begin
        wrap_exp = up ? (m_val == 99) : (m_val == 0);
        m_val    = up ? (m_val + 1) % 100 : (m_val + 99) % 100;
      end
      if (wrap_exp) m_ovf = 1;
      else if (clr) m_ovf = 0;
    end
    e.tag  = tag;
    e.q    = to_bcd(m_val);
    e.wrap = wrap_exp;
    e.ovf  = m_ovf;
    e.le   = le_exp;
    sb.push_back(e);

    MR_n = mr; Enable = en; Up = up; Load = ld; P = p; ClrOvf = clr;
    #1;
    if (m_known) chk({tag, ".tc"}, 32'(TC), 32'(tc_exp));
    @(posedge clk);
    #1;
    if (!mr) m_known = 1;
    e = sb.pop_front();
    chk({e.tag, ".q"},    32'(Q),       32'(e.q));
    chk({e.tag, ".wrap"}, 32'(Wrap),    32'(e.wrap));
    chk({e.tag, ".ovf"},  32'(Ovf),     32'(e.ovf));
    chk({e.tag, ".lerr"}, 32'(LoadErr), 32'(e.le));
  endtask

  initial begin
    MR_n = 0; Enable = 0; Up = 1; Load = 0; P = '0; ClrOvf = 0;
    ch_mr = 0; ch_en0 = 0; ch_load = 0; ch_p = '0; ch_clr = 0;

    step("rst0", 0, 1, 1, 1, 8'h55, 0);
    step("rst1", 0, 1, 1, 1, 8'h55, 0);
    step("first", 1, 1, 1, 0, 8'h00, 0);
    chk("first_const", 32'(Q), 32'h01);

    step("ld97", 1, 0, 1, 1, 8'h97, 0);
    step("up98", 1, 1, 1, 0, 8'h00, 0);
    step("up99", 1, 1, 1, 0, 8'h00, 0);
    step("up00", 1, 1, 1, 0, 8'h00, 0);
    chk("wrap_up_const", 32'({Q, Wrap, Ovf}), 32'({8'h00, 1'b1, 1'b1}));
    step("hold", 1, 0, 1, 0, 8'h00, 0);

    step("dn99", 1, 1, 0, 0, 8'h00, 0);
    chk("wrap_dn_const", 32'({Q, Wrap}), 32'({8'h99, 1'b1}));
    step("dn98", 1, 1, 0, 0, 8'h00, 0);

    step("ld3c", 1, 0, 1, 1, 8'h3C, 0);
    chk("ld3c_const", 32'({Q, LoadErr}), 32'({8'h30, 1'b1}));
    step("ld3c_after", 1, 0, 1, 0, 8'h00, 0);
    step("lda0", 1, 1, 0, 1, 8'hA0, 0);

    step("ld99", 1, 0, 1, 1, 8'h99, 0);
    step("ld55_en", 1, 1, 1, 1, 8'h55, 0);
    step("ld99b", 1, 0, 1, 1, 8'h99, 1);
    step("wrap_clr", 1, 1, 1, 0, 8'h00, 1);
    step("clr_only", 1, 0, 1, 0, 8'h00, 1);
    chk("clr_const", 32'(Ovf), 32'h0);

    step("cnt_a", 1, 1, 1, 0, 8'h00, 0);
    step("cnt_b", 1, 1, 1, 0, 8'h00, 0);
    step("mid_rst", 0, 1, 1, 0, 8'h00, 0);
    step("resume", 1, 1, 1, 0, 8'h00, 0);

    for (int i = 0; i < 40; i++) begin
      logic r_ld;
      r_ld = ($urandom_range(0, 7) == 0);
      step("rand", ($urandom_range(0, 31) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), r_ld, 8'($urandom_range(0, 255)),
           ($urandom_range(0, 5) == 0));
    end
    for (int i = 0; i < 105; i++) step("long_up", 1, 1, 1, 0, 8'h00, 0);

    ch_mr = 0; ch_en0 = 1;
    @(posedge clk); #1;
    chk("ch_rst", 32'({q1, q0}), 32'h0);
    ch_mr = 1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      chk("ch_q0", 32'(q0), 32'(n % 6));
      chk("ch_q1", 32'(q1), 32'((n / 6) % 6));
      chk("ch_wrap1", 32'(wrap1), 32'(n == 36));
    end
    chk("ch_final", 32'({q1, q0}), 32'({3'd0, 3'd4}));
    chk("ch_ovf1", 32'(ovf1), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
